serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Multi-cycle, digit-serial N-bit subtractor: diff = a - b - borrow_in.
//  Borrow chain uses full-subtractor logic:
//    d = x^y^bi;  bo = (~x&(y^bi)) | (y&bi)
//  Processes DIGIT bits per clock, LSB digit first, with a registered borrow between digits.
//  Sits between operand producers and result consumers on valid/ready handshakes.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be >= 1.
//  DIGIT   4  bits processed per cycle; must divide WIDTH, else elaboration $error.
// PORTS
//  clk         in   1      single clock, rising edge.
//  rst_n       in   1      asynchronous, active-low reset.
//  in_valid    in   1      operands valid.
//  in_ready    out  1      block can accept operands.
//  a           in   WIDTH  minuend, unsigned or two's complement.
//  b           in   WIDTH  subtrahend.
//  borrow_in   in   1      initial borrow into bit 0.
//  out_valid   out  1      result valid; held until accepted.
//  out_ready   in   1      consumer accepts the result.
//  diff        out  WIDTH  a - b - borrow_in, mod 2^WIDTH.
//  borrow_out  out  1      borrow out of the MSB (1 = unsigned underflow).
//  ovf         out  1      signed overflow; only present with SERSUB_OVF_EN.
// BEHAVIOUR
//  Reset values: in_ready=0, out_valid=0, diff=0, borrow_out=0, ovf=0, state=IDLE, count=0.
//  After deassertion, in_ready goes to 1 on the first clock edge.
//  Reset asserted mid-operation aborts the operation immediately. The partial result is discarded.
//  FSM:
//    IDLE: in_ready=1. in_valid&in_ready at an edge latches a, b, borrow_in, sets count=0 -> RUN.
//    RUN: in_ready=0. Each edge computes digit[count] with the registered borrow,
//      writes that digit of the diff register, updates the borrow, count++.
//      At the edge where count==N-1 (N=WIDTH/DIGIT): -> DONE, out_valid=1,
//      borrow_out=final borrow.
//    DONE: out_valid=1 and diff/borrow_out stable until an edge with out_ready=1.
//      On that edge: -> IDLE, out_valid=0.
//  Latency:
//    Accept edge at cycle T; out_valid is high from cycle T+N. If out_ready=1, it stays high 1 cycle.
//    Throughput: one operation per N+2 cycles. No overlap of accept and result.
//  in_valid asserted while not in IDLE is ignored. The producer must hold it.
//    Operands are sampled only on the accept edge.
//    Changes to a, b or borrow_in afterwards have no effect.
//  DIGIT==WIDTH: N=1, single RUN cycle.
//  count width is $clog2(N), minimum 1. count never exceeds N-1; no wrap.
//  Out-of-range or unknown state: next state is IDLE.
// CONFIGURATION
//  `SERSUB_OVF_EN defined:
//    Port ovf exists.
//    ovf = (a[MSB]^b[MSB]) & (diff[MSB]^a[MSB]), using the latched operands.
//    ovf is valid with out_valid and held with diff.
//  Not defined: no ovf port, no overflow logic. All other behaviour is identical.
// STRUCTURE
//  Package sersub_pkg:
//    state_t enum {IDLE, RUN, DONE}, 2-bit encoding.
//    Function fs_bit(x, y, bi) returning {bo, d}.
//  Sub-module fs_digit #(DIGIT):
//    Purely combinational ripple of DIGIT fs_bit cells.
//    Inputs: x[DIGIT], y[DIGIT], bi. Outputs: d[DIGIT], bo.
//    One instance, muxed by count.
// TESTING (WIDTH=16, DIGIT=4 unless noted)
//  1. a=0x0005, b=0x0003, bin=0
//     -> diff=0x0002, borrow_out=0; out_valid exactly 4 cycles after accept.
//  2. a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, borrow_out=1.
//     Checks borrow ripple across all digits.
//  3. a=0x1234, b=0x1234, bin=1 -> diff=0xFFFF, borrow_out=1.
//     a=0xFFFF, b=0x0000, bin=1 -> diff=0xFFFE, borrow_out=0.
//  4. out_ready held 0 for 5 cycles in DONE -> out_valid/diff stable, in_ready=0, new in_valid ignored.
//     Then out_ready=1 -> IDLE next cycle.
//  5. rst_n pulsed low during RUN (count=2) -> outputs 0 immediately.
//     A fresh op 0x00FF-0x0001 then gives diff=0x00FE.
//  6. With SERSUB_OVF_EN:
//     0x8000-0x0001 -> 0x7FFF, ovf=1.
//     0x7FFF-0xFFFF -> 0x8000, ovf=1.
//     0x0003-0x0001 -> ovf=0.
//     Repeat tests 1-3 with DIGIT=1 and DIGIT=16.

Source files
------------

// File: rtl/sersub_pkg.sv
// Shared types and bit-level helper for the digit-serial subtractor.
//   state_t : controller states, 2-bit encoding
//   fs_bit  : one full-subtractor cell, returns {borrow_out, difference}
package sersub_pkg;

    localparam int unsigned SERSUB_WIDTH_DEF = 16;
    localparam int unsigned SERSUB_DIGIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [1:0] fs_bit(input logic x, input logic y, input logic bi);
        logic d;
        logic bo;
        d  = x ^ y ^ bi;
        bo = (~x & (y ^ bi)) | (y & bi);
        return {bo, d};
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
//   master : producer/consumer side (drives in_valid, a, b, borrow_in, out_ready)
//   slave  : subtractor side (drives in_ready, out_valid, diff, borrow_out[, ovf])
// ovf exists only when SERSUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERSUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, borrow_in, out_ready,
        input  in_ready, out_valid, diff, borrow_out
`ifdef SERSUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, borrow_in, out_ready,
        output in_ready, out_valid, diff, borrow_out
`ifdef SERSUB_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/fs_digit.sv
// Combinational ripple of DIGIT full-subtractor cells.
//   x, y : digit operands      bi : borrow in
//   d    : digit difference    bo : borrow out of the digit MSB
module fs_digit
    import sersub_pkg::*;
#(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo
);

    logic       w_c;
    logic [1:0] w_r;

    // Borrow ripples LSB to MSB through the cell chain
    always_comb begin
        w_c = bi;
        w_r = 2'b00;
        d   = '0;
        for (int i = 0; i < int'(DIGIT); i++) begin
            w_r  = fs_bit(x[i], y[i], w_c);
            d[i] = w_r[0];
            w_c  = w_r[1];
        end
        bo = w_c;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - borrow_in, DIGIT bits per clock, LSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : serial_subtractor_if.slave (operand and result valid/ready handshakes)
// Optional: define SERSUB_OVF_EN to add the signed-overflow output bus.ovf.
module serial_subtractor
    import sersub_pkg::*;
#(
    parameter int unsigned WIDTH = SERSUB_WIDTH_DEF,
    parameter int unsigned DIGIT = SERSUB_DIGIT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned MSB  = WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_subtractor: DIGIT must be >= 1 and divide WIDTH");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_borrow_out;

    logic             w_accept;
    logic             w_last;
    logic [31:0]      w_shamt;
    logic [DIGIT-1:0] w_x;
    logic [DIGIT-1:0] w_y;
    logic [DIGIT-1:0] w_d;
    logic             w_bo;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_diff_run;

    assign w_accept = (r_state == IDLE) && r_in_ready && bus.in_valid;
    assign w_last   = (r_count == LAST);

    // Select the active digit by shifting; avoids variable part-selects
    assign w_shamt    = 32'(r_count) * 32'(DIGIT);
    assign w_x        = DIGIT'(r_a >> w_shamt);
    assign w_y        = DIGIT'(r_b >> w_shamt);
    assign w_mask     = WIDTH'({DIGIT{1'b1}}) << w_shamt;
    assign w_diff_run = (r_diff & ~w_mask) | (WIDTH'(w_d) << w_shamt);

    fs_digit #(.DIGIT(DIGIT)) u_fs_digit (
        .x  (w_x),
        .y  (w_y),
        .bi (r_borrow),
        .d  (w_d),
        .bo (w_bo)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; illegal encodings fall back to IDLE
    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE:    w_state_nxt = w_accept ? RUN : IDLE;
            RUN:     w_state_nxt = w_last ? DONE : RUN;
            DONE:    w_state_nxt = bus.out_ready ? IDLE : DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count      <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_diff       <= '0;
            r_borrow     <= 1'b0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_borrow_out <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_borrow <= bus.borrow_in;
                        r_count  <= '0;
                    end
                end
                RUN: begin
                    r_diff   <= w_diff_run;
                    r_borrow <= w_bo;
                    if (w_last) begin
                        r_borrow_out <= w_bo;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERSUB_OVF_EN
    logic r_ovf;

    // Signed overflow from latched operand signs and the final result sign
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_ovf <= (r_a[MSB] ^ r_b[MSB]) & (w_diff_run[MSB] ^ r_a[MSB]);
        end
    end

    assign bus.ovf = r_ovf;
`endif

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow_out;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized + directed bench for serial_subtractor at WIDTH=16 with DIGIT=4, 1 and 16.
// The reference is plain 17-bit / signed integer arithmetic.
module tb_serial_subtractor;

    localparam int unsigned WIDTH = 16;

    logic clk;
    logic rst_n;

    int n_vec;
    int n_err;

    serial_subtractor_if #(.WIDTH(WIDTH)) if4  ();
    serial_subtractor_if #(.WIDTH(WIDTH)) if1  ();
    serial_subtractor_if #(.WIDTH(WIDTH)) if16 ();

    serial_subtractor #(.WIDTH(WIDTH), .DIGIT(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4.slave)
    );

    serial_subtractor #(.WIDTH(WIDTH), .DIGIT(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    serial_subtractor #(.WIDTH(WIDTH), .DIGIT(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive the same operands into all three instances and check each result
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bin);
        logic [16:0] full;
        int          sr;
        logic        exp_ovf;
        bit          seen [3];
        int          lat  [3];
        logic [15:0] gd   [3];
        logic        gb   [3];
        logic        go   [3];
        int          exp_lat [3];
        int          k;

        full    = {1'b0, a} - {1'b0, b} - 17'(bin);
        sr      = int'($signed(a)) - int'($signed(b)) - int'(bin);
        exp_ovf = (sr > 32767) || (sr < -32768);
        exp_lat[0] = 4;
        exp_lat[1] = 16;
        exp_lat[2] = 1;
        for (int i = 0; i < 3; i++) begin
            seen[i] = 1'b0;
            lat[i]  = 0;
            gd[i]   = '0;
            gb[i]   = 1'b0;
            go[i]   = 1'b0;
        end

        k = 0;
        while (!(if4.in_ready && if1.in_ready && if16.in_ready) && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 50) begin
            check_val("idle_timeout", 32'd0, 32'd1);
            return;
        end

        if4.a = a;  if4.b = b;  if4.borrow_in = bin;  if4.out_ready = 1'b1;  if4.in_valid = 1'b1;
        if1.a = a;  if1.b = b;  if1.borrow_in = bin;  if1.out_ready = 1'b1;  if1.in_valid = 1'b1;
        if16.a = a; if16.b = b; if16.borrow_in = bin; if16.out_ready = 1'b1; if16.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if4.in_valid = 1'b0; if1.in_valid = 1'b0; if16.in_valid = 1'b0;
        // Post-accept operand changes must not matter
        if4.a = ~a; if1.b = ~b; if16.borrow_in = ~bin;

        for (int c = 1; c <= 40 && !(seen[0] && seen[1] && seen[2]); c++) begin
            if (!seen[0] && if4.out_valid) begin
                seen[0] = 1'b1; lat[0] = c - 1; gd[0] = if4.diff; gb[0] = if4.borrow_out;
`ifdef SERSUB_OVF_EN
                go[0] = if4.ovf;
`endif
            end
            if (!seen[1] && if1.out_valid) begin
                seen[1] = 1'b1; lat[1] = c - 1; gd[1] = if1.diff; gb[1] = if1.borrow_out;
`ifdef SERSUB_OVF_EN
                go[1] = if1.ovf;
`endif
            end
            if (!seen[2] && if16.out_valid) begin
                seen[2] = 1'b1; lat[2] = c - 1; gd[2] = if16.diff; gb[2] = if16.borrow_out;
`ifdef SERSUB_OVF_EN
                go[2] = if16.ovf;
`endif
            end
            if (!(seen[0] && seen[1] && seen[2])) begin
                @(posedge clk);
                #1;
            end
        end

        for (int i = 0; i < 3; i++) begin
            if (!seen[i]) begin
                check_val($sformatf("timeout_d%0d a=%h b=%h", exp_lat[i], a, b), 32'd0, 32'd1);
            end else begin
                check_val($sformatf("lat_n%0d", exp_lat[i]), 32'(lat[i]), 32'(exp_lat[i]));
                check_val($sformatf("diff_n%0d %h-%h-%0d", exp_lat[i], a, b, bin), 32'(gd[i]), 32'(full[15:0]));
                check_val($sformatf("bout_n%0d %h-%h-%0d", exp_lat[i], a, b, bin), 32'(gb[i]), 32'(full[16]));
`ifdef SERSUB_OVF_EN
                check_val($sformatf("ovf_n%0d %h-%h-%0d", exp_lat[i], a, b, bin), 32'(go[i]), 32'(exp_ovf));
`endif
            end
        end
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rbin;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        if4.in_valid = 1'b0;  if4.a = '0;  if4.b = '0;  if4.borrow_in = 1'b0;  if4.out_ready = 1'b1;
        if1.in_valid = 1'b0;  if1.a = '0;  if1.b = '0;  if1.borrow_in = 1'b0;  if1.out_ready = 1'b1;
        if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.borrow_in = 1'b0; if16.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready",   32'(if4.in_ready),   32'd0);
        check_val("rst_out_valid",  32'(if4.out_valid),  32'd0);
        check_val("rst_diff",       32'(if4.diff),       32'd0);
        check_val("rst_borrow_out", 32'(if4.borrow_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("first_edge_in_ready", 32'(if4.in_ready), 32'd1);

        // Directed vectors
        do_op(16'h0005, 16'h0003, 1'b0);
        do_op(16'h0000, 16'h0001, 1'b0);
        do_op(16'h1234, 16'h1234, 1'b1);
        do_op(16'hFFFF, 16'h0000, 1'b1);
        do_op(16'h8000, 16'h0001, 1'b0);
        do_op(16'h7FFF, 16'hFFFF, 1'b0);
        do_op(16'h0003, 16'h0001, 1'b0);

        // Result held while consumer stalls; new in_valid ignored
        @(posedge clk);
        #1;
        if4.a = 16'h0005; if4.b = 16'h0003; if4.borrow_in = 1'b0;
        if4.out_ready = 1'b0; if4.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if4.a = 16'hAAAA; if4.b = 16'h1111;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("stall%0d_out_valid", i), 32'(if4.out_valid), 32'd1);
            check_val($sformatf("stall%0d_diff", i),      32'(if4.diff),      32'h0002);
            check_val($sformatf("stall%0d_in_ready", i),  32'(if4.in_ready),  32'd0);
            @(posedge clk);
            #1;
        end
        if4.in_valid  = 1'b0;
        if4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("release_out_valid", 32'(if4.out_valid), 32'd0);
        check_val("release_in_ready",  32'(if4.in_ready),  32'd1);

        // Reset in the middle of RUN (count == 2)
        if4.a = 16'h1234; if4.b = 16'h0000; if4.borrow_in = 1'b0; if4.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if4.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("midrst_diff",      32'(if4.diff),       32'd0);
        check_val("midrst_out_valid", 32'(if4.out_valid),  32'd0);
        check_val("midrst_in_ready",  32'(if4.in_ready),   32'd0);
        check_val("midrst_bout",      32'(if4.borrow_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h00FF, 16'h0001, 1'b0);

        // Random vectors
        for (int i = 0; i < 40; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rbin = 1'($urandom);
            do_op(ra, rb, rbin);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
